// File: rtl/demux_if.sv
// demux_if: receive-side symbol bus into the demux and the decoded frame/status outputs.
interface demux_if;
   logic [7:0] rx_DataE;
   logic       rx_dk;
   logic       rx_Valid;
   logic [7:0] rx_DataD;
   logic       rx_DataD_valid;
   logic [3:0] control_dk;
   logic       pkt_start;
   logic       pkt_type;
   logic       pkt_end;
   logic       pkt_abort;
   logic [7:0] pkt_len;
   logic       err_framing;
   logic       locked;
   modport master (
      output rx_DataE, rx_dk, rx_Valid,
      input  rx_DataD, rx_DataD_valid, control_dk, pkt_start, pkt_type,
             pkt_end, pkt_abort, pkt_len, err_framing, locked
   );
   modport slave (
      input  rx_DataE, rx_dk, rx_Valid,
      output rx_DataD, rx_DataD_valid, control_dk, pkt_start, pkt_type,
             pkt_end, pkt_abort, pkt_len, err_framing, locked
   );
endinterface

// File: rtl/demux.sv
// demux: K-symbol classifier with COM-based symbol lock and TLP/DLLP framing.
module demux (
   input  logic   clk,
   input  logic   rst,
   input  logic   enb,
   demux_if.slave bus
);
   localparam logic [7:0] COM = 8'hBC, SKP = 8'h1C, STP = 8'hFB, SDP = 8'h5C;
   localparam logic [7:0] ENDK = 8'hFD, EDB = 8'hFE, FTS = 8'h3C, IDLE = 8'h7C;
   localparam logic [3:0] C_DATA = 4'd0, C_COM = 4'd1, C_SKP = 4'd2, C_STP = 4'd3, C_SDP = 4'd4;
   localparam logic [3:0] C_END = 4'd5, C_EDB = 4'd6, C_FTS = 4'd7, C_IDLE = 4'd8, C_UNK = 4'd15;
   typedef enum logic {UNLOCKED, LOCKED} lock_t;
   typedef enum logic [1:0] {OUT, TLP, DLLP} frame_t;
   lock_t      lock_q, lock_d;
   frame_t     frame_q, frame_d;
   logic [2:0] com_cnt_q, com_cnt_d;
   logic [1:0] err_cnt_q, err_cnt_d;
   logic [7:0] len_q, len_d;
   logic [7:0] data_q, data_d, plen_q, plen_d;
   logic [3:0] ctrl_q, ctrl_d, cls;
   logic       dv_q, dv_d, start_q, start_d, type_q, type_d;
   logic       end_q, end_d, abort_q, abort_d, ferr_q, ferr_d;
   always_comb begin
      cls = !bus.rx_dk          ? C_DATA :
            bus.rx_DataE == COM  ? C_COM  :
            bus.rx_DataE == SKP  ? C_SKP  :
            bus.rx_DataE == STP  ? C_STP  :
            bus.rx_DataE == SDP  ? C_SDP  :
            bus.rx_DataE == ENDK ? C_END  :
            bus.rx_DataE == EDB  ? C_EDB  :
            bus.rx_DataE == FTS  ? C_FTS  :
            bus.rx_DataE == IDLE ? C_IDLE : C_UNK;
   end
   always_comb begin
      lock_d    = lock_q;
      frame_d   = frame_q;
      com_cnt_d = com_cnt_q;
      err_cnt_d = err_cnt_q;
      len_d     = len_q;
      data_d    = data_q;
      plen_d    = plen_q;
      ctrl_d    = ctrl_q;
      type_d    = type_q;
      dv_d      = 1'b0;
      start_d   = 1'b0;
      end_d     = 1'b0;
      abort_d   = 1'b0;
      ferr_d    = 1'b0;
      if (bus.rx_Valid) begin
         ctrl_d = cls;
         if (lock_q == UNLOCKED) begin
            com_cnt_d = (cls == C_COM) ? com_cnt_q + 3'd1 : 3'd0;
            if (cls == C_COM && com_cnt_q == 3'd3) begin
               lock_d    = LOCKED;
               com_cnt_d = 3'd0;
               err_cnt_d = 2'd0;
            end
         end else begin
            if (frame_q == OUT) begin
               if (cls == C_STP || cls == C_SDP) begin
                  frame_d = (cls == C_STP) ? TLP : DLLP;
                  type_d  = (cls == C_SDP);
                  start_d = 1'b1;
                  len_d   = 8'd0;
               end else begin
                  ferr_d = (cls == C_DATA || cls == C_END || cls == C_EDB || cls == C_UNK);
               end
            end else if (cls == C_DATA) begin
               data_d = bus.rx_DataE;
               dv_d   = 1'b1;
               len_d  = (len_q == 8'hFF) ? len_q : len_q + 8'd1;
            end else if (cls != C_SKP) begin
               // any non-SKP K-symbol inside a frame closes it; only END counts as a clean close
               frame_d = OUT;
               plen_d  = len_q;
               end_d   = (cls == C_END);
               abort_d = (cls != C_END);
               ferr_d  = (cls != C_END && cls != C_EDB);
            end
            err_cnt_d = ferr_d ? err_cnt_q + 2'd1 : 2'd0;
            if (ferr_d && err_cnt_q == 2'd3) begin
               lock_d    = UNLOCKED;
               frame_d   = OUT;
               err_cnt_d = 2'd0;
            end
         end
      end
   end
   always_ff @(posedge clk) begin
      if (rst || !enb) begin
         lock_q    <= UNLOCKED;
         frame_q   <= OUT;
         com_cnt_q <= 3'd0;
         err_cnt_q <= 2'd0;
         len_q     <= 8'd0;
         data_q    <= 8'd0;
         plen_q    <= 8'd0;
         ctrl_q    <= 4'd0;
         type_q    <= 1'b0;
         dv_q      <= 1'b0;
         start_q   <= 1'b0;
         end_q     <= 1'b0;
         abort_q   <= 1'b0;
         ferr_q    <= 1'b0;
      end else begin
         lock_q    <= lock_d;
         frame_q   <= frame_d;
         com_cnt_q <= com_cnt_d;
         err_cnt_q <= err_cnt_d;
         len_q     <= len_d;
         data_q    <= data_d;
         plen_q    <= plen_d;
         ctrl_q    <= ctrl_d;
         type_q    <= type_d;
         dv_q      <= dv_d;
         start_q   <= start_d;
         end_q     <= end_d;
         abort_q   <= abort_d;
         ferr_q    <= ferr_d;
      end
   end
   assign bus.rx_DataD       = data_q;
   assign bus.rx_DataD_valid = dv_q;
   assign bus.control_dk     = ctrl_q;
   assign bus.pkt_start      = start_q;
   assign bus.pkt_type       = type_q;
   assign bus.pkt_end        = end_q;
   assign bus.pkt_abort      = abort_q;
   assign bus.pkt_len        = plen_q;
   assign bus.err_framing    = ferr_q;
   assign bus.locked         = (lock_q == LOCKED);
endmodule

// File: tb/tb_demux.sv
// tb_demux: vector table plus scoreboard queue; each driven symbol pushes its expected outputs one clock ahead.
module tb_demux;
   localparam logic [7:0] COM = 8'hBC, SKP = 8'h1C, STP = 8'hFB, SDP = 8'h5C;
   localparam logic [7:0] ENDK = 8'hFD, EDB = 8'hFE, FTS = 8'h3C, IDLE = 8'h7C;
   localparam logic [5:0] DV = 6'b100000, ST = 6'b010000, EN = 6'b001000;
   localparam logic [5:0] AB = 6'b000100, FE = 6'b000010, LK = 6'b000001;
   typedef struct {
      logic r, off, v, k;
      logic [7:0] b;
      logic [3:0] ctrl;
      logic [5:0] f;
      logic ty;
      logic [7:0] len;
      logic full;
   } vec_t;
   logic clk = 1'b0, rst = 1'b1, enb = 1'b1;
   int tests = 0, fails = 0;
   vec_t tbl[$];
   vec_t sb[$];
   vec_t e;
   logic [26:0] act, exp_v, msk;
   demux_if bus ();
   demux dut (.clk(clk), .rst(rst), .enb(enb), .bus(bus));
   always #5 clk = ~clk;
   function automatic vec_t sym(logic k, logic [7:0] b, logic [3:0] c, logic [5:0] f, logic t, logic [7:0] l);
      vec_t x;
      x = '{r: 1'b0, off: 1'b0, v: 1'b1, k: k, b: b, ctrl: c, f: f, ty: t, len: l, full: 1'b0};
      return x;
   endfunction
   function automatic vec_t gap(logic [3:0] c, logic t, logic lk);
      vec_t x;
      x = '{r: 1'b0, off: 1'b0, v: 1'b0, k: 1'b1, b: STP, ctrl: c, f: lk ? LK : 6'd0, ty: t, len: 8'd0, full: 1'b0};
      return x;
   endfunction
   function automatic vec_t rstv(logic off);
      vec_t x;
      x = '{r: !off, off: off, v: 1'b1, k: 1'b1, b: COM, ctrl: 4'd0, f: 6'd0, ty: 1'b0, len: 8'd0, full: 1'b1};
      return x;
   endfunction
   task automatic apply(input vec_t x);
      @(negedge clk);
      rst = x.r;
      enb = !x.off;
      bus.rx_Valid = x.v;
      bus.rx_dk = x.k;
      bus.rx_DataE = x.b;
      sb.push_back(x);
   endtask
   task automatic relock();
      for (int i = 0; i < 3; i++) apply(sym(1, COM, 1, 0, 0, 0));
      apply(sym(1, COM, 1, LK, 0, 0));
   endtask
   always @(posedge clk) begin
      #1;
      if (sb.size() != 0) begin
         e = sb.pop_front();
         act = {bus.control_dk, bus.rx_DataD_valid, bus.rx_DataD, bus.pkt_start, bus.pkt_type,
                bus.pkt_end, bus.pkt_abort, bus.pkt_len, bus.err_framing, bus.locked};
         exp_v = {e.ctrl, e.f[5], e.f[5] ? e.b : 8'h00, e.f[4], e.ty, e.f[3], e.f[2], e.len, e.f[1], e.f[0]};
         msk = {4'hF, 1'b1, (e.full || e.f[5]) ? 8'hFF : 8'h00, 4'hF,
                (e.full || e.f[3] || e.f[2]) ? 8'hFF : 8'h00, 2'b11};
         tests++;
         if ((act & msk) !== (exp_v & msk)) begin
            fails++;
            $display("FAIL vec%0d: got %h required %h (mask %h)", tests, act, exp_v, msk);
         end
      end
   end
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "timeout");
   end
   initial begin
      bus.rx_Valid = 1'b0;
      bus.rx_dk = 1'b0;
      bus.rx_DataE = 8'h00;
      for (int i = 0; i < 3; i++) tbl.push_back(sym(1, COM, 1, 0, 0, 0));
      tbl.push_back(sym(1, IDLE, 8, 0, 0, 0));
      for (int i = 0; i < 3; i++) tbl.push_back(sym(1, COM, 1, 0, 0, 0));
      tbl.push_back(sym(1, COM, 1, LK, 0, 0));
      tbl.push_back(sym(1, STP, 3, ST | LK, 0, 0));
      tbl.push_back(sym(0, 8'hFF, 0, DV | LK, 0, 0));
      tbl.push_back(sym(0, 8'hFF, 0, DV | LK, 0, 0));
      tbl.push_back(sym(1, ENDK, 5, EN | LK, 0, 2));
      tbl.push_back(gap(5, 0, 1));
      tbl.push_back(sym(1, SDP, 4, ST | LK, 1, 0));
      for (int i = 1; i <= 5; i++) tbl.push_back(sym(0, 8'(i), 0, DV | LK, 1, 0));
      tbl.push_back(sym(1, SKP, 2, LK, 1, 0));
      tbl.push_back(gap(2, 1, 1));
      for (int i = 6; i <= 10; i++) tbl.push_back(sym(0, 8'(i), 0, DV | LK, 1, 0));
      tbl.push_back(sym(1, EDB, 6, AB | LK, 1, 10));
      tbl.push_back(sym(1, STP, 3, ST | LK, 0, 0));
      tbl.push_back(sym(0, 8'h33, 0, DV | LK, 0, 0));
      tbl.push_back(sym(1, IDLE, 8, FE | AB | LK, 0, 1));
      tbl.push_back(sym(0, 8'h44, 0, FE | LK, 0, 0));
      tbl.push_back(sym(1, COM, 1, LK, 0, 0));
      tbl.push_back(sym(1, 8'hAA, 15, FE | LK, 0, 0));
      tbl.push_back(sym(0, 8'h55, 0, FE | LK, 0, 0));
      tbl.push_back(sym(1, EDB, 6, FE | LK, 0, 0));
      tbl.push_back(sym(1, FTS, 7, LK, 0, 0));
      for (int i = 0; i < 3; i++) tbl.push_back(sym(1, ENDK, 5, FE | LK, 0, 0));
      tbl.push_back(sym(1, ENDK, 5, FE, 0, 0));
      tbl.push_back(sym(1, STP, 3, 0, 0, 0));
      tbl.push_back(sym(0, 8'h12, 0, 0, 0, 0));
      tbl.push_back(sym(1, 8'hAA, 15, 0, 0, 0));
      apply(rstv(0));
      foreach (tbl[i]) apply(tbl[i]);
      relock();
      apply(sym(1, STP, 3, ST | LK, 0, 0));
      for (int i = 0; i < 300; i++) apply(sym(0, 8'(i * 7), 0, DV | LK, 0, 0));
      apply(sym(1, ENDK, 5, EN | LK, 0, 255));
      apply(sym(1, STP, 3, ST | LK, 0, 0));
      apply(sym(0, 8'h77, 0, DV | LK, 0, 0));
      apply(rstv(0));
      apply(sym(0, 8'h88, 0, 0, 0, 0));
      relock();
      apply(sym(1, SDP, 4, ST | LK, 1, 0));
      apply(sym(0, 8'h99, 0, DV | LK, 1, 0));
      apply(rstv(1));
      apply(sym(1, COM, 1, 0, 0, 0));
      repeat (3) @(negedge clk);
      tests++;
      if (sb.size() != 0) begin
         fails++;
         $display("FAIL drain: %0d entries left, required 0", sb.size());
      end
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
